// File: rtl/lab5_spi_pkg.sv
// Shared constants and FSM state type for the lab5 SPI slave.
// Register map and status/control bit positions used by the CPU port.
package lab5_spi_pkg;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int BIT_ROE  = 3;
  localparam int BIT_TOE  = 4;
  localparam int BIT_TMT  = 5;
  localparam int BIT_TRDY = 6;
  localparam int BIT_RRDY = 7;
  localparam int BIT_E    = 8;
  localparam int BIT_TUR  = 9;

  // Writable interrupt enables; TMT (bit 5) has no enable and reads back 0.
  localparam logic [15:0] CTRL_WMASK = 16'h03D8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Purpose: multi-flop synchronizer for an asynchronous pin with rise/fall pulses.
// Latency: SYNC_STAGES clk to sync_out; rise/fall are combinational off the last two flops.
// Backpressure: none; a pin must hold each level for at least two clk cycles.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Reset to 0 so a pin already low at reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule

// File: rtl/lab5_spi_slave.sv
// Purpose: mode-0 8-bit SPI slave with a two-cycle CPU register port and IRQ.
// Latency: MISO MSB ~SYNC_STAGES+2 clk after SS_n falls; RRDY ~SYNC_STAGES+1 after 8th SCLK rise.
// Backpressure: none; lost bytes are reported through ROE/TOE/TUR flags.
module lab5_spi_slave
  import lab5_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  mem_addr,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
);

  logic unused_sclk_s;
  logic sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (SCLK),
    .sync_out (unused_sclk_s),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (SS_n),
    .sync_out (ss_s),
    .rise     (ss_rise),
    .fall     (ss_fall)
  );

  // MOSI shares SCLK's delay so the sampled bit lines up with the detected edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mosi_sync <= '0;
    else          mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  spi_slv_state_t state;
  logic [7:0]  tx_holding, tx_shift, rx_shift, rx_holding;
  logic        tx_primed, reload;
  logic [2:0]  bitcnt;
  logic        roe, toe, tur, rrdy;
  logic [15:0] ctrl, status, rd_mux;
  logic        strobe, p1_strobe, cpu_rd, cpu_wr;
  logic        tx_wr, stat_wr, ctrl_wr, rx_rd, rrdy_clr;
  logic        load_now, byte_done;

  assign p1_strobe = ~strobe & spi_select & (~read_n | ~write_n);
  assign cpu_rd    = p1_strobe & ~read_n;
  assign cpu_wr    = p1_strobe & ~write_n;
  assign tx_wr     = cpu_wr & (mem_addr == ADDR_TXDATA);
  assign stat_wr   = cpu_wr & (mem_addr == ADDR_STATUS);
  assign ctrl_wr   = cpu_wr & (mem_addr == ADDR_CONTROL);
  assign rx_rd     = cpu_rd & (mem_addr == ADDR_RXDATA);
  assign rrdy_clr  = rx_rd | stat_wr;

  assign load_now  = ((state == LOAD) && !ss_rise) ||
                     ((state == SHIFT) && !ss_rise && sclk_fall && reload);
  assign byte_done = (state == SHIFT) && !ss_rise && sclk_rise && (bitcnt == 3'd7);

  always_comb begin
    status           = '0;
    status[BIT_ROE]  = roe;
    status[BIT_TOE]  = toe;
    status[BIT_TMT]  = (state == IDLE) & ~tx_primed;
    status[BIT_TRDY] = ~tx_primed;
    status[BIT_RRDY] = rrdy;
    status[BIT_E]    = roe | toe | tur;
    status[BIT_TUR]  = tur;
  end

  always_comb begin
    rd_mux = '0;
    case (mem_addr)
      ADDR_RXDATA:  rd_mux = {8'h00, rx_holding};
      ADDR_STATUS:  rd_mux = status;
      ADDR_CONTROL: rd_mux = ctrl;
      default:      rd_mux = '0;
    endcase
  end

  // Transfer engine: tx_primed/tx_holding are read pre-cycle, so a same-cycle CPU write misses this load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_holding <= '0;
      bitcnt     <= '0;
      reload     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ss_fall) state <= LOAD;
        LOAD: begin
          if (ss_rise) begin
            state <= IDLE;
          end else begin
            tx_shift <= tx_primed ? tx_holding : 8'h00;
            bitcnt   <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state  <= IDLE;
            bitcnt <= '0;
            reload <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              if (bitcnt == 3'd7) begin
                rx_holding <= {rx_shift[6:0], mosi_s};
                bitcnt     <= '0;
                reload     <= 1'b1;
              end else begin
                bitcnt <= bitcnt + 3'd1;
              end
            end
            if (sclk_fall) begin
              if (reload) begin
                tx_shift <= tx_primed ? tx_holding : 8'h00;
                reload   <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // CPU port and flags: every flag set takes priority over its clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe      <= 1'b0;
      data_to_cpu <= '0;
      tx_holding  <= '0;
      tx_primed   <= 1'b0;
      ctrl        <= '0;
      rrdy        <= 1'b0;
      roe         <= 1'b0;
      toe         <= 1'b0;
      tur         <= 1'b0;
      irq         <= 1'b0;
      MISO_oe     <= 1'b0;
    end else begin
      strobe <= p1_strobe;
      if (cpu_rd)  data_to_cpu <= rd_mux;
      if (ctrl_wr) ctrl <= data_from_cpu & CTRL_WMASK;

      if (tx_wr && !tx_primed) begin
        tx_holding <= data_from_cpu[7:0];
        tx_primed  <= 1'b1;
      end else if (load_now) begin
        tx_primed  <= 1'b0;
      end

      if (byte_done)     rrdy <= 1'b1;
      else if (rrdy_clr) rrdy <= 1'b0;

      if (byte_done && rrdy && !rrdy_clr) roe <= 1'b1;
      else if (stat_wr)                   roe <= 1'b0;

      if (tx_wr && tx_primed) toe <= 1'b1;
      else if (stat_wr)       toe <= 1'b0;

      if (load_now && !tx_primed) tur <= 1'b1;
      else if (stat_wr)           tur <= 1'b0;

      irq <= |(status & ctrl);

      if (ss_s)         MISO_oe <= 1'b0;
      else if (ss_fall) MISO_oe <= 1'b1;
    end
  end

  assign MISO = MISO_oe & tx_shift[7];

endmodule
